signmag_to_twos26: RTL and testbench

//  Streaming inverse of the 26-bit absolute-value stage: converts {sign, magnitude} back to 26-bit two's complement.

---
 rtl/signmag_to_twos26.sv | 147 ++++++++++++++
 tb/tb_signmag_to_twos26.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signmag_to_twos26.sv
// Converts a {sign, magnitude} stream back to N-bit two's complement through a
// 2-stage valid/ready pipeline, flagging and counting saturated samples.
module signmag_to_twos26 #(
  parameter int N     = 26,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_mag,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sat,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  localparam logic [N-1:0]     MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             adv;
  logic             out_xfer;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [N-1:0]     s1_mag_q, s1_mag_d;
  logic             s1_sat_pos_q, s1_sat_pos_d;
  logic             s1_sat_neg_q, s1_sat_neg_d;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             sat_sticky_q, sat_sticky_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  logic [N-1:0]     neg_carry;
  logic [N-1:0]     neg_mag;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign out_xfer = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sat_sticky_q;
  assign sat_count  = sat_count_q;

  // Increment of ~mag: bit i flips when every lower magnitude bit is zero.
  assign neg_carry[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_carry
      assign neg_carry[gi] = neg_carry[gi-1] & ~s1_mag_q[gi-1];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_neg
      assign neg_mag[gi] = ~s1_mag_q[gi] ^ neg_carry[gi];
    end
  endgenerate

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_mag_d     = s1_mag_q;
    s1_sat_pos_d = s1_sat_pos_q;
    s1_sat_neg_d = s1_sat_neg_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d    = in_sign;
        s1_mag_d     = in_mag;
        s1_sat_pos_d = !in_sign && (in_mag > MAX_POS);
        s1_sat_neg_d = in_sign && (in_mag > MIN_NEG);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sat_d = s1_sat_pos_q || s1_sat_neg_q;
        if (s1_sat_pos_q) begin
          out_data_d = MAX_POS;
        end else if (s1_sat_neg_q) begin
          out_data_d = MIN_NEG;
        end else if (s1_sign_q) begin
          out_data_d = neg_mag;
        end else begin
          out_data_d = s1_mag_q;
        end
      end
    end
  end

  // A saturated transfer in the same cycle as a clear restarts the count at one.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    sat_count_d  = sat_count_q;
    if (out_xfer && out_sat_q) begin
      sat_sticky_d = 1'b1;
      if (sat_clr) begin
        sat_count_d = CNT_ONE;
      end else if (sat_count_q != CNT_MAX) begin
        sat_count_d = sat_count_q + CNT_ONE;
      end
    end else if (sat_clr) begin
      sat_sticky_d = 1'b0;
      sat_count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_mag_q     <= '0;
      s1_sat_pos_q <= 1'b0;
      s1_sat_neg_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      sat_sticky_q <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_mag_q     <= s1_mag_d;
      s1_sat_pos_q <= s1_sat_pos_d;
      s1_sat_neg_q <= s1_sat_neg_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      sat_sticky_q <= sat_sticky_d;
      sat_count_q  <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_signmag_to_twos26.sv
// Bench for signmag_to_twos26: arithmetic reference model with a scoreboard queue,
// checked every negedge, plus directed vectors with literal expectations.
module tb_signmag_to_twos26;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_mag;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_data;
  logic        out_sat;
  logic        sat_sticky;
  logic [15:0] sat_count;
  logic        sat_clr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [25:0] mag;
    logic        sign;
    logic [25:0] data;
    logic        sat;
  } item_t;

  item_t exp_q[$];
  int    m_cnt;
  bit    m_sticky;
  bit    stall_prev;
  logic [25:0] prev_data;
  logic        prev_sat;

  logic [25:0] t4_mag [8];
  logic        t4_sign[8];
  logic        rdy_pat[20];

  signmag_to_twos26 dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_sticky(sat_sticky), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Signed value clamped to the representable range, then reduced mod 2^26.
  function automatic item_t model(input logic [25:0] mag, input logic sign);
    item_t  r;
    longint v;
    logic [63:0] u;
    v = sign ? -longint'(mag) : longint'(mag);
    r.sat = 1'b0;
    if (v > 64'sd33554431) begin
      v = 33554431; r.sat = 1'b1;
    end else if (v < -64'sd33554432) begin
      v = -33554432; r.sat = 1'b1;
    end
    u = v;
    r.mag = mag; r.sign = sign; r.data = u[25:0];
    return r;
  endfunction

  // Single compare process: everything is stable at the negedge for the coming edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_cnt = 0; m_sticky = 1'b0; stall_prev = 1'b0;
    end else begin
      item_t e;
      logic signed [25:0] sd;
      longint a;
      bit got;
      got = 1'b0;
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("sat_count", sat_count, m_cnt);
      chk("sat_sticky", sat_sticky, m_sticky);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_sat", out_sat, prev_sat);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = exp_q[0];
          got = 1'b1;
          chk("model_data", out_data, e.data);
          chk("model_sat", out_sat, e.sat);
          if (!e.sat && e.mag != 0) begin
            sd = out_data;
            a = (sd < 0) ? -longint'(sd) : longint'(sd);
            chk("roundtrip_mag", a, e.mag);
            chk("roundtrip_sign", out_data[25], e.sign);
          end
        end
      end
      if (out_valid && out_ready && got) begin
        void'(exp_q.pop_front());
        if (e.sat) begin
          m_sticky = 1'b1;
          m_cnt = sat_clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
        end else if (sat_clr) begin
          m_cnt = 0; m_sticky = 1'b0;
        end
      end else if (sat_clr) begin
        m_cnt = 0; m_sticky = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_mag, in_sign));
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_sat = out_sat;
    end
  end

  // One sample on an empty pipeline with out_ready=1: latency and literal result.
  task automatic send_expect(input logic [25:0] m, input logic s, input logic [25:0] ed,
                             input logic es, input string nm);
    int lat;
    lat = 0;
    in_mag = m; in_sign = s; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid = 1'b0;
      if (out_valid) lat = c;
    end
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_data"}, out_data, ed);
    chk({nm, "_sat"}, out_sat, es);
    $display("vec %s: mag=0x%07h sign=%0d -> data=0x%07h sat=%0d lat=%0d",
             nm, m, s, out_data, out_sat, lat);
  endtask

  task automatic load_sample(input int idx, input bit rnd);
    if (!rnd) begin
      in_mag = t4_mag[idx]; in_sign = t4_sign[idx];
    end else begin
      case ($urandom_range(0, 7))
        0: in_mag = 26'h2000000;
        1: in_mag = 26'h1FFFFFF;
        2: in_mag = 26'h2000001;
        3: in_mag = 26'h0000000;
        4: in_mag = 26'h3FFFFFF;
        default: in_mag = 26'($urandom);
      endcase
      in_sign = 1'($urandom);
    end
  endtask

  task automatic stream(input int n, input bit rnd, input int budget);
    int  idx, cyc;
    bit  x;
    idx = 0; cyc = 0;
    load_sample(0, rnd);
    in_valid = 1'b1;
    while (idx < n && cyc < budget) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : rdy_pat[cyc % 20];
      @(negedge clk);
      x = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (x) begin
        idx++;
        if (idx < n) load_sample(idx, rnd);
      end
    end
    in_valid = 1'b0;
    chk("stream_all_accepted", idx, n);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || out_valid); c++) begin
      @(posedge clk); #1;
    end
    chk("stream_drained", exp_q.size(), 0);
    $display("stream: %0d samples in %0d cycles", idx, cyc);
  endtask

  initial begin
    t4_mag  = '{26'd1, 26'd2, 26'h2000000, 26'h0ABCDEF, 26'h3FFFFFF, 26'd0, 26'h1FFFFFF, 26'h2000000};
    t4_sign = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rdy_pat = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};

    reset_n = 1'b0; in_valid = 1'b0; in_mag = '0; in_sign = 1'b0;
    out_ready = 1'b0; sat_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sticky", sat_sticky, 0);
    chk("rst_count", sat_count, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    send_expect(26'd5,       1'b1, 26'h3FFFFFB, 1'b0, "neg5");
    send_expect(26'd0,       1'b1, 26'h0000000, 1'b0, "negzero");
    send_expect(26'h2000000, 1'b1, 26'h2000000, 1'b0, "minneg");
    send_expect(26'h1FFFFFF, 1'b0, 26'h1FFFFFF, 1'b0, "maxpos");
    send_expect(26'h0ABCDEF, 1'b1, 26'h3543211, 1'b0, "negmid");
    send_expect(26'h2000000, 1'b0, 26'h1FFFFFF, 1'b1, "satpos");
    send_expect(26'h3FFFFFF, 1'b1, 26'h2000000, 1'b1, "satneg");
    @(posedge clk); #1;
    chk("sat_count_2", sat_count, 2);
    chk("sat_sticky_1", sat_sticky, 1);

    // Clear coinciding with a saturated transfer: new event wins.
    send_expect(26'h3FFFFFF, 1'b0, 26'h1FFFFFF, 1'b1, "satpos_max");
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_with_sat_count", sat_count, 1);
    chk("clr_with_sat_sticky", sat_sticky, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_alone_count", sat_count, 0);
    chk("clr_alone_sticky", sat_sticky, 0);

    stream(8, 1'b0, 200);

    // Asynchronous reset with two samples in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; in_mag = 26'h3FFFFFF; in_sign = 1'b1;
    @(posedge clk); #1;
    in_mag = 26'd7; in_sign = 1'b0;
    @(posedge clk); #1;
    in_mag = 26'd9; in_sign = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_sticky", sat_sticky, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_out_sat", out_sat, 0);
    chk("async_sticky", sat_sticky, 0);
    chk("async_count", sat_count, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("post_reset_no_out", out_valid, 0);
    end
    $display("reset: in-flight samples dropped");

    stream(10000, 1'b1, 40000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
